// File: rtl/pcs_dec_lite.sv
// pcs_dec_lite: lightweight 64b/66b receive block decoder.
// Classifies each descrambled block (D/C/S/T/E), tracks framing with a
// four-state receive FSM, and registers the decoded payload, byte mask and
// block-kind flags with one cycle of latency.
// Optional feature: define PCS_DEC_ERR_CNT_EN to add an 8-bit saturating
// error counter on port err_cnt_o.
module pcs_dec_lite #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [1:0]        sync_head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              idle_v_o,
  output logic              term_v_o,
  output logic              err_v_o,
  output logic [1:0]        start_v_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o
`ifdef PCS_DEC_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RX_INIT = 2'd0,
    RX_C    = 2'd1,
    RX_D    = 2'd2,
    RX_E    = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    CLS_D = 3'd0,
    CLS_C = 3'd1,
    CLS_S = 3'd2,
    CLS_T = 3'd3,
    CLS_E = 3'd4
  } blk_cls_t;

  rx_state_t         state_r;
  rx_state_t         state_nxt_s;
  blk_cls_t          cls_s;
  logic [2:0]        term_n_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] term_data_s;
  logic [KEEP_W-1:0] term_keep_s;
  logic              idle_s;
  logic              term_s;
  logic              err_s;
  logic [1:0]        start_s;
  logic [DATA_W-1:0] data_s;
  logic [KEEP_W-1:0] keep_s;

  // Classify the incoming block from its sync header and block-type byte.
  always_comb begin
    cls_s    = CLS_E;
    term_n_s = 3'd0;
    if (sync_head_i == 2'b01) begin
      cls_s = CLS_D;
    end else if (sync_head_i == 2'b10) begin
      case (data_i[7:0])
        8'h1E: begin
          if (data_i[DATA_W-1:8] == 56'd0) begin
            cls_s = CLS_C;
          end else begin
            cls_s = CLS_E;
          end
        end
        8'h78, 8'h33: cls_s = CLS_S;
        8'h87: begin cls_s = CLS_T; term_n_s = 3'd0; end
        8'h99: begin cls_s = CLS_T; term_n_s = 3'd1; end
        8'hAA: begin cls_s = CLS_T; term_n_s = 3'd2; end
        8'hB4: begin cls_s = CLS_T; term_n_s = 3'd3; end
        8'hCC: begin cls_s = CLS_T; term_n_s = 3'd4; end
        8'hD2: begin cls_s = CLS_T; term_n_s = 3'd5; end
        8'hE1: begin cls_s = CLS_T; term_n_s = 3'd6; end
        8'hFF: begin cls_s = CLS_T; term_n_s = 3'd7; end
        default: cls_s = CLS_E;
      endcase
    end else begin
      cls_s = CLS_E;
    end
  end

  // Build the terminate payload: the n bytes after the type byte, low-aligned.
  always_comb begin
    shifted_s   = {8'h00, data_i[DATA_W-1:8]};
    term_keep_s = '0;
    term_data_s = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      if (b < int'(term_n_s)) begin
        term_keep_s[b]       = 1'b1;
        term_data_s[b*8 +: 8] = shifted_s[b*8 +: 8];
      end else begin
        term_keep_s[b]       = 1'b0;
        term_data_s[b*8 +: 8] = 8'h00;
      end
    end
  end

  // Next receive state; the FSM only moves when a block is presented.
  always_comb begin
    state_nxt_s = state_r;
    if (valid_i) begin
      case (state_r)
        RX_D: begin
          case (cls_s)
            CLS_D:   state_nxt_s = RX_D;
            CLS_T:   state_nxt_s = RX_C;
            default: state_nxt_s = RX_E;
          endcase
        end
        default: begin
          case (cls_s)
            CLS_C:   state_nxt_s = RX_C;
            CLS_S:   state_nxt_s = RX_D;
            default: state_nxt_s = RX_E;
          endcase
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decode the block; an error class or a transition into RX_E wins over all.
  always_comb begin
    idle_s  = 1'b0;
    term_s  = 1'b0;
    err_s   = 1'b0;
    start_s = 2'b00;
    data_s  = '0;
    keep_s  = '0;
    if (valid_i) begin
      if ((cls_s == CLS_E) || (state_nxt_s == RX_E)) begin
        err_s  = 1'b1;
        data_s = {KEEP_W{8'hFE}};
        keep_s = '0;
      end else begin
        case (cls_s)
          CLS_D: begin
            data_s = data_i;
            keep_s = {KEEP_W{1'b1}};
          end
          CLS_C: idle_s = 1'b1;
          CLS_S: begin
            if (data_i[7:0] == 8'h33) begin
              start_s = 2'b10;
              data_s  = {data_i[DATA_W-1:40], 40'h0};
              keep_s  = 8'hE0;
            end else begin
              start_s = 2'b01;
              data_s  = {data_i[DATA_W-1:8], 8'h00};
              keep_s  = 8'hFE;
            end
          end
          CLS_T: begin
            term_s = 1'b1;
            data_s = term_data_s;
            keep_s = term_keep_s;
          end
          default: err_s = 1'b0;
        endcase
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // Receive state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RX_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered decoder outputs, one cycle behind the input block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o   <= 1'b0;
      idle_v_o  <= 1'b0;
      term_v_o  <= 1'b0;
      err_v_o   <= 1'b0;
      start_v_o <= 2'b00;
      data_o    <= '0;
      keep_o    <= '0;
    end else begin
      valid_o   <= valid_i;
      idle_v_o  <= idle_s;
      term_v_o  <= term_s;
      err_v_o   <= err_s;
      start_v_o <= start_s;
      data_o    <= data_s;
      keep_o    <= keep_s;
    end
  end

`ifdef PCS_DEC_ERR_CNT_EN
  // Saturating error counter, updated together with err_v_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_o <= 8'h00;
    end else if (err_s && (err_cnt_o != 8'hFF)) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end else begin
      err_cnt_o <= err_cnt_o;
    end
  end
`endif

endmodule
